// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, requester IDs,
// default widths and the round-robin helper functions.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 31;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef enum logic [1:0] {RQ_PU = 2'd0, RQ_IO = 2'd1, RQ_PNL = 2'd2} rq_id_t;

  // Rotation order PU -> IO -> PNL -> PU.
  function automatic rq_id_t rq_next(input rq_id_t id);
    case (id)
      RQ_PU:   return RQ_IO;
      RQ_IO:   return RQ_PNL;
      default: return RQ_PU;
    endcase
  endfunction

  function automatic logic rq_pending(input logic [2:0] req, input rq_id_t id);
    case (id)
      RQ_PU:   return req[0];
      RQ_IO:   return req[1];
      RQ_PNL:  return req[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin grant; the search starts just after the
// last granted requester, whose pointer register lives in the parent.
module rr_arbiter3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  rq_id_t     last,
  output logic       gnt_valid,
  output rq_id_t     gnt_id
);

  rq_id_t cand1;
  rq_id_t cand2;

  assign cand1 = rq_next(last);
  assign cand2 = rq_next(cand1);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = last;
    if (rq_pending(req, cand1)) begin
      gnt_id = cand1;
    end else if (rq_pending(req, cand2)) begin
      gnt_id = cand2;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises PU reads, IO writes and panel accesses onto one memory port.
// Optional WAIT timeout is enabled with `define MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no access; grant one pending requester and latch its access
// S_ISSUE | one-cycle read or write strobe to memory
// S_WAIT  | waiting for the reply matching the latched operation
// S_DONE  | one-cycle ack to the granted requester; advance RR pointer
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pu_req,
  input  logic [ADDR_W-1:0] pu_addr,
  output logic              pu_ack,
  output logic [DATA_W-1:0] pu_rdata,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  input  logic              pnl_req,
  input  logic              pnl_we,
  input  logic [ADDR_W-1:0] pnl_addr,
  input  logic [DATA_W-1:0] pnl_wdata,
  output logic              pnl_ack,
  output logic [DATA_W-1:0] pnl_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_read_reply,
  input  logic              mem_write_reply,
  output logic              busy,
  output logic              timeout_err
);

  state_t              state_q, state_d;
  rq_id_t              last_q, acc_id, gnt_id;
  logic                gnt_valid;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                reply_ok;
  logic                expired;

  rr_arbiter3 u_rr (
    .req       ({pnl_req, io_req, pu_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign reply_ok = acc_we ? mem_write_reply : mem_read_reply;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  logic          tmo_err_q;

  // Expires on the last of TIMEOUT_CYCLES WAIT cycles without a matching reply.
  assign expired = (state_q == S_WAIT) && !reply_ok && (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) begin
        tmr_q <= TW'(TIMEOUT_CYCLES - 1);
      end else if (state_q == S_WAIT && tmr_q != '0) begin
        tmr_q <= tmr_q - 1'b1;
      end
      if (expired) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= RQ_PU;
      acc_id    <= RQ_PU;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            acc_id  <= gnt_id;
            rdata_q <= '0;
            case (gnt_id)
              RQ_PU: begin
                acc_we   <= 1'b0;
                acc_addr <= pu_addr;
              end
              RQ_IO: begin
                acc_we    <= 1'b1;
                acc_addr  <= io_addr;
                acc_wdata <= io_wdata;
              end
              default: begin
                acc_we    <= pnl_we;
                acc_addr  <= pnl_addr;
                acc_wdata <= pnl_wdata;
              end
            endcase
          end
        end
        S_WAIT: begin
          if (reply_ok && !acc_we) begin
            rdata_q <= mem_rdata;
          end else if (expired) begin
            rdata_q <= '0;
          end
        end
        S_DONE:  last_q <= acc_id;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (reply_ok || expired) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_read  = (state_q == S_ISSUE) && !acc_we;
  assign mem_write = (state_q == S_ISSUE) && acc_we;
  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_wdata;
  assign busy      = (state_q != S_IDLE);

  assign pu_ack    = (state_q == S_DONE) && (acc_id == RQ_PU);
  assign io_ack    = (state_q == S_DONE) && (acc_id == RQ_IO);
  assign pnl_ack   = (state_q == S_DONE) && (acc_id == RQ_PNL);
  assign pu_rdata  = pu_ack  ? rdata_q : '0;
  assign pnl_rdata = pnl_ack ? rdata_q : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port memory (4096 x 31-bit words: sign + 30 data bits, 12-bit octal address) between three requesters: processor read (PU), I/O write (IO), and control-panel read/write (PNL). Sits between those units and the memory, driving its read/write strobes, address select value and write word. Serialises accesses, holds address and data stable for the whole access, and returns read data and a completion pulse to the granted requester.

Parameters:
ADDR_W, 12, word address width
DATA_W, 31, word width (bit 30 = sign)
TIMEOUT_CYCLES, 15, maximum WAIT cycles before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
pu_req  in  1  PU read request, level
pu_addr  in  ADDR_W  PU read address
pu_ack  out  1  one-cycle completion pulse to PU
pu_rdata  out  DATA_W  PU read word, valid while pu_ack=1
io_req  in  1  IO write request, level
io_addr  in  ADDR_W  IO write address
io_wdata  in  DATA_W  IO write word
io_ack  out  1  one-cycle completion pulse to IO
pnl_req  in  1  panel request, level
pnl_we  in  1  1 = write, 0 = read
pnl_addr  in  ADDR_W  panel address
pnl_wdata  in  DATA_W  panel write word
pnl_ack  out  1  one-cycle completion pulse to panel
pnl_rdata  out  DATA_W  panel read word, valid while pnl_ack=1
mem_read  out  1  one-cycle read strobe to memory
mem_write  out  1  one-cycle write strobe to memory
mem_addr  out  ADDR_W  memory select value
mem_wdata  out  DATA_W  memory write word
mem_rdata  in  DATA_W  memory read word, valid with mem_read_reply
mem_read_reply  in  1  memory read-complete pulse
mem_write_reply  in  1  memory write-complete pulse
busy  out  1  state != IDLE
timeout_err  out  1  sticky abort flag (0 without MEM_ARB_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE; all outputs 0; RR pointer = PU, so first contended grant order is IO, PNL, PU.
- Requester rule: each req is held high with address/data stable until its ack. Dropping req early is a protocol error; the block still completes the latched access. A requester may re-assert req in the cycle after ack.
- State IDLE: if any req is high, grant one requester by round-robin (priority rotates PU->IO->PNL, starting after the last granted). Latch addr, wdata and op into the access registers (op: PU=read, IO=write, PNL=pnl_we). Go to ISSUE.
- State ISSUE (1 cycle): assert mem_read or mem_write for exactly one cycle. mem_addr and mem_wdata come from the access registers; they are stable from ISSUE until leaving WAIT. Go to WAIT.
- State WAIT: on the reply matching op (mem_read_reply for reads, mem_write_reply for writes), capture mem_rdata into the read register on reads, then go to DONE. A non-matching reply is ignored.
- State DONE (1 cycle): pulse the granted requester's ack. Its rdata output equals the captured word; non-granted rdata outputs are 0. Advance the RR pointer to the granted requester. Go to IDLE.
- Latency with nominal memory (reply 2 cycles after strobe): req seen in cycle 0 -> strobe in cycle 1 -> reply in cycle 3 -> ack in cycle 4. Next grant in cycle 5. Throughput is one access per 5 cycles.
- Simultaneous requests: only one grant per IDLE cycle; the losers remain pending and are not lost.
- Reset mid-access: return immediately to IDLE and drop the access with no ack. A late memory reply arriving in IDLE is ignored.
- mem_addr and mem_wdata hold their last value while IDLE. No strobe is ever issued outside ISSUE.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined: a counter runs in WAIT. If no matching reply arrives within TIMEOUT_CYCLES cycles, go to DONE, ack the requester with rdata = 0, and set timeout_err. timeout_err stays set until reset.
- Undefined: WAIT has no bound, there is no counter, and timeout_err is tied to 0.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE, ISSUE, WAIT, DONE), requester ID encoding (PU=0, IO=1, PNL=2), ADDR_W/DATA_W defaults.
- One sub-module, rr_arbiter3: 3-way round-robin grant from req[2:0] and last-grant pointer; combinational, with the pointer register kept in the parent.

Test Plan:
- Single PU read, addr 12'o1234, memory model returns 31'h4000_0005 -> mem_read pulse in cycle 1 with mem_addr=12'o1234; pu_ack in cycle 4 with pu_rdata=31'h4000_0005.
- IO write, addr 12'o7777, wdata 31'h2AAA_AAAA -> one mem_write pulse with that addr and word; io_ack once; pu_ack and pnl_ack stay 0.
- PU, IO and PNL read all asserted from reset -> grants IO, PNL, PU in that order; each ack 5 cycles apart; all three complete.
- Panel write, then panel read of the same address 12'o0100 with data 31'h7FFF_FFFF -> pnl_rdata=31'h7FFF_FFFF on the second pnl_ack.
- reset asserted in WAIT, with the reply arriving 1 cycle after reset deasserts -> no ack; busy=0; stray reply ignored; next request served normally.
- With MEM_ARB_TIMEOUT_EN and a memory model that never replies -> ack after 15 WAIT cycles with rdata 0; timeout_err=1 until reset.
